// File: rtl/adventure_pkg.sv
// Shared types for the adventure room FSM: room codes, direction indices and
// the single-button qualifier.
package adventure_pkg;

    typedef enum logic [2:0] {
        CAVE      = 3'd0,
        TUNNEL    = 3'd1,
        RIVER     = 3'd2,
        STASH     = 3'd3,
        DEN       = 3'd4,
        VICTORY   = 3'd5,
        GRAVEYARD = 3'd6
    } room_t;

    localparam int unsigned DIR_W = 4;
    localparam int unsigned DIR_N = 0;
    localparam int unsigned DIR_S = 1;
    localparam int unsigned DIR_E = 2;
    localparam int unsigned DIR_W_IDX = 3;

    // True when exactly one direction bit is set.
    function automatic logic one_dir(input logic [DIR_W-1:0] d);
        return (d != '0) && ((d & (d - DIR_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/adventure_room_fsm_dir_edge.sv
// Registered rising-edge detector for the four direction buttons
// (used only when ADVENTURE_DIR_EDGE_EN is defined).
module dir_edge
    import adventure_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [DIR_W-1:0] btn_i,
    output logic [DIR_W-1:0] pulse_o
);

    logic [DIR_W-1:0] btn_q;
    logic [DIR_W-1:0] pulse_q;

    // Pulse is registered so a press reaches the FSM one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= '0;
            pulse_q <= '0;
        end else begin
            btn_q   <= btn_i;
            pulse_q <= btn_i & ~btn_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/adventure_room_fsm.sv
// Seven-room navigation FSM with saturating move counter.
// Optional ADVENTURE_DIR_EDGE_EN: buttons act on rising edges instead of levels.
module adventure_room_fsm
    import adventure_pkg::*;
#(
    parameter int unsigned MOVE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    input  logic              v,
    output logic              sw,
    output logic              win,
    output logic              dead,
    output logic [2:0]        room,
    output logic [MOVE_W-1:0] moves
);

    logic [DIR_W-1:0]  dir_raw;
    logic [DIR_W-1:0]  dir_req;
    logic              dir_ok;
    room_t             room_q, room_d;
    logic              step_d;
    logic [MOVE_W-1:0] moves_q;
    logic              sw_q, win_q, dead_q;

    always_comb begin
        dir_raw            = '0;
        dir_raw[DIR_N]     = n;
        dir_raw[DIR_S]     = s;
        dir_raw[DIR_E]     = e;
        dir_raw[DIR_W_IDX] = w;
    end

`ifdef ADVENTURE_DIR_EDGE_EN
    dir_edge u_dir_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (dir_raw),
        .pulse_o (dir_req)
    );
`else
    assign dir_req = dir_raw;
`endif

    assign dir_ok = one_dir(dir_req);

    // Next room; step_d marks button-driven room changes only.
    always_comb begin
        room_d = room_q;
        step_d = 1'b0;
        case (room_q)
            CAVE: begin
                if (dir_ok && dir_req[DIR_E]) begin
                    room_d = TUNNEL;
                    step_d = 1'b1;
                end
            end
            TUNNEL: begin
                if (dir_ok && dir_req[DIR_S]) begin
                    room_d = RIVER;
                    step_d = 1'b1;
                end else if (dir_ok && dir_req[DIR_W_IDX]) begin
                    room_d = CAVE;
                    step_d = 1'b1;
                end
            end
            RIVER: begin
                if (dir_ok && dir_req[DIR_W_IDX]) begin
                    room_d = STASH;
                    step_d = 1'b1;
                end else if (dir_ok && dir_req[DIR_N]) begin
                    room_d = TUNNEL;
                    step_d = 1'b1;
                end else if (dir_ok && dir_req[DIR_E]) begin
                    room_d = DEN;
                    step_d = 1'b1;
                end
            end
            STASH: begin
                if (dir_ok && dir_req[DIR_E]) begin
                    room_d = RIVER;
                    step_d = 1'b1;
                end
            end
            DEN:       room_d = v ? VICTORY : GRAVEYARD;
            VICTORY:   room_d = VICTORY;
            GRAVEYARD: room_d = GRAVEYARD;
            default:   room_d = CAVE;
        endcase
    end

    // Flags are registered from the next room so they track room_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            room_q  <= CAVE;
            moves_q <= '0;
            sw_q    <= 1'b0;
            win_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            room_q <= room_d;
            if (step_d && (moves_q != '1)) begin
                moves_q <= moves_q + MOVE_W'(1);
            end
            sw_q   <= (room_d == STASH);
            win_q  <= (room_d == VICTORY);
            dead_q <= (room_d == GRAVEYARD);
        end
    end

    assign room  = room_q;
    assign moves = moves_q;
    assign sw    = sw_q;
    assign win   = win_q;
    assign dead  = dead_q;

endmodule

// File: tb/tb_adventure_room_fsm.sv
// Directed self-checking bench for adventure_room_fsm, with a behavioural
// sword latch feeding v back from sw.
module tb_adventure_room_fsm;

    localparam int unsigned MOVE_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
    logic              v;
    logic              sw, win, dead;
    logic [2:0]        room;
    logic [MOVE_W-1:0] moves;

    logic use_latch = 1'b1;
    logic v_force   = 1'b0;
    logic v_latch;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Sword latch model: captures sw and holds until reset.
    always @(posedge clk) begin
        if (reset)   v_latch <= 1'b0;
        else if (sw) v_latch <= 1'b1;
    end

    assign v = use_latch ? v_latch : v_force;

    adventure_room_fsm #(.MOVE_W(MOVE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .n     (n),
        .s     (s),
        .e     (e),
        .w     (w),
        .v     (v),
        .sw    (sw),
        .win   (win),
        .dead  (dead),
        .room  (room),
        .moves (moves)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        n = 0; s = 0; e = 0; w = 0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    // One button press; edge mode needs a release cycle to let the pulse land.
    task automatic press(input logic pn, input logic ps, input logic pe, input logic pw);
        n = pn; s = ps; e = pe; w = pw;
        @(posedge clk);
`ifdef ADVENTURE_DIR_EDGE_EN
        n = 0; s = 0; e = 0; w = 0;
        @(posedge clk);
`endif
        #1;
        n = 0; s = 0; e = 0; w = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag, input int r, input int m,
                               input logic esw, input logic ewin, input logic edead);
        check({tag, ".room"},  32'(room),  32'(r));
        check({tag, ".moves"}, 32'(moves), 32'(m));
        check({tag, ".sw"},    32'(sw),    32'(esw));
        check({tag, ".win"},   32'(win),   32'(ewin));
        check({tag, ".dead"},  32'(dead),  32'(edead));
    endtask

    initial begin
        // Reset and idle
        do_reset();
        idle(5);
        check_state("reset_idle", 0, 0, 0, 0, 0);

        // Win path: E S W E E with latch-driven v
        use_latch = 1'b1;
        press(0, 0, 1, 0); check_state("win_e1", 1, 1, 0, 0, 0);
        press(0, 1, 0, 0); check_state("win_s",  2, 2, 0, 0, 0);
        press(0, 0, 0, 1); check_state("win_w",  3, 3, 1, 0, 0);
        press(0, 0, 1, 0); check_state("win_e2", 2, 4, 0, 0, 0);
        press(0, 0, 1, 0); check_state("win_e3", 4, 5, 0, 0, 0);
        idle(1);           check_state("win_vv", 5, 5, 0, 1, 0);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1); check_state("win_hold", 5, 5, 0, 1, 0);

        // Death path: E S E with v=0
        use_latch = 1'b0; v_force = 1'b0;
        do_reset();
        check_state("death_rst", 0, 0, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0); check_state("death_den", 4, 3, 0, 0, 0);
        idle(1);           check_state("death_gy",  6, 3, 0, 0, 1);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        press(0, 0, 1, 0); check_state("death_hold", 6, 3, 0, 0, 1);

        // Unqualified or exit-less directions in RIVER
        do_reset();
        press(0, 0, 1, 0);
        press(0, 1, 0, 0); check_state("river", 2, 2, 0, 0, 0);
        press(1, 0, 1, 0); check_state("river_ne",   2, 2, 0, 0, 0);
        press(0, 1, 0, 0); check_state("river_s",    2, 2, 0, 0, 0);
        press(1, 1, 1, 1); check_state("river_all",  2, 2, 0, 0, 0);
        press(1, 0, 0, 0); check_state("river_n",    1, 3, 0, 0, 0);

        // Reset while in DEN with v=1 must never reach VICTORY
        do_reset();
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0); check_state("den_pre", 4, 3, 0, 0, 0);
        v_force = 1'b1;
        reset = 1'b1;
        idle(1);           check_state("den_rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        idle(2);           check_state("den_after", 0, 0, 0, 0, 0);

        // Hold E for 10 cycles from CAVE
        do_reset();
        e = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
`ifdef ADVENTURE_DIR_EDGE_EN
            check($sformatf("hold_room_%0d", i), 32'(room), (i >= 2) ? 32'd1 : 32'd0);
            check($sformatf("hold_moves_%0d", i), 32'(moves), (i >= 2) ? 32'd1 : 32'd0);
`else
            check($sformatf("hold_room_%0d", i), 32'(room), 32'd1);
            check($sformatf("hold_moves_%0d", i), 32'(moves), 32'd1);
`endif
        end
        e = 1'b0;

        // Saturation: 300 accepted E/W moves clamp at 255
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) press(0, 0, 1, 0);
            else            press(0, 0, 0, 1);
        end
        check("sat_moves", 32'(moves), 32'd255);
        check("sat_room",  32'(room),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
